// File: rtl/rle_enc_param.sv
// Parametrised run-length encoder: reads SYM_W-bit symbols from DPSRAM port A and writes
// little-endian (count, symbol) records back, truncating cleanly at an output byte limit.
module rle_enc_param #(
  parameter int SYM_W = 8,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] message_size,
  input  logic [31:0] rle_addr,
  input  logic [31:0] rle_limit,
  output logic [31:0] rle_size,
  output logic        done,
  output logic        overflow,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic [31:0] port_A_data_in,
  input  logic [31:0] port_A_data_out,
  output logic        port_A_we,
  output logic [3:0]  state_dbg
);
  localparam int REC_W = CNT_W + SYM_W;
  localparam int R     = REC_W / 8;
  localparam int SPW   = 32 / SYM_W;
  localparam logic [1:0]       LAST_IDX = 2'(SPW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Handshake: start is sampled only in IDLE/DONE and accepted on the first edge it is high;
  // done drops on that edge and stays high from frame end until the next accepted start.
  typedef enum logic [3:0] {IDLE, RD_REQ, RD_WAIT, SCAN, EMIT, WR, FLUSH, DONE} state_t;

  state_t             state, ret;
  logic [15:0]        rd_addr, wr_addr;
  logic [31:0]        sym_left;
  logic [1:0]         sym_idx;
  logic               first;
  logic [31:0]        word_q;
  logic               have_run;
  logic [SYM_W-1:0]   run_sym, emit_sym;
  logic [CNT_W-1:0]   run_cnt, emit_cnt;
  logic [31:0]        acc;
  logic [1:0]         acc_n;

  logic [31:0]        cur_word;
  logic [SYM_W-1:0]   cur_sym;
  logic [63:0]        merged;
  logic [2:0]         total;
  logic [32:0]        size_next;
  logic [31:0]        nsym;
  logic               last_in_word;
  state_t             after_sym;
  logic               unused_bits;

  assign port_A_clk  = clk;
  assign state_dbg   = state;
  assign unused_bits = ^{message_addr[31:16], rle_addr[31:16]};

  // The freshly read word is only on the bus during the first SCAN cycle; later cycles use the copy.
  always_comb begin
    cur_word     = first ? port_A_data_out : word_q;
    cur_sym      = SYM_W'(cur_word >> (6'(sym_idx) * 6'(SYM_W)));
    merged       = {32'd0, acc} | (64'({emit_sym, emit_cnt}) << (6'(acc_n) * 6'd8));
    total        = 3'(acc_n) + 3'(R);
    size_next    = {1'b0, rle_size} + 33'(R);
    nsym         = message_size / 32'(SYM_W / 8);
    last_in_word = (sym_idx == LAST_IDX);
    after_sym    = (sym_left == 32'd1) ? FLUSH : (last_in_word ? RD_REQ : SCAN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      ret            <= IDLE;
      rle_size       <= '0;
      done           <= 1'b0;
      overflow       <= 1'b0;
      port_A_addr    <= '0;
      port_A_data_in <= '0;
      port_A_we      <= 1'b0;
      rd_addr        <= '0;
      wr_addr        <= '0;
      sym_left       <= '0;
      sym_idx        <= '0;
      first          <= 1'b0;
      word_q         <= '0;
      have_run       <= 1'b0;
      run_sym        <= '0;
      run_cnt        <= '0;
      emit_sym       <= '0;
      emit_cnt       <= '0;
      acc            <= '0;
      acc_n          <= '0;
    end else begin
      port_A_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            rle_size <= '0;
            overflow <= 1'b0;
            have_run <= 1'b0;
            acc      <= '0;
            acc_n    <= '0;
            sym_idx  <= '0;
            sym_left <= nsym;
            rd_addr  <= message_addr[15:0];
            wr_addr  <= rle_addr[15:0];
            if (nsym == 32'd0) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              done  <= 1'b0;
              state <= RD_REQ;
            end
          end
        end
        RD_REQ: begin
          port_A_addr <= rd_addr;
          rd_addr     <= rd_addr + 16'd4;
          first       <= 1'b1;
          state       <= RD_WAIT;
        end
        RD_WAIT: state <= SCAN;
        SCAN: begin
          if (first) begin
            word_q <= port_A_data_out;
            first  <= 1'b0;
          end
          sym_left <= sym_left - 32'd1;
          sym_idx  <= last_in_word ? 2'd0 : sym_idx + 2'd1;
          if (!have_run) begin
            have_run <= 1'b1;
            run_sym  <= cur_sym;
            run_cnt  <= CNT_W'(1);
            state    <= after_sym;
          end else if (cur_sym == run_sym && run_cnt != CNT_MAX) begin
            run_cnt <= run_cnt + CNT_W'(1);
            state   <= after_sym;
          end else begin
            emit_sym <= run_sym;
            emit_cnt <= run_cnt;
            run_sym  <= cur_sym;
            run_cnt  <= CNT_W'(1);
            ret      <= after_sym;
            state    <= EMIT;
          end
        end
        EMIT: begin
          if (size_next > {1'b0, rle_limit}) begin
            // Drop this and every later record; only bytes already accepted get flushed.
            overflow <= 1'b1;
            have_run <= 1'b0;
            state    <= FLUSH;
          end else begin
            rle_size <= size_next[31:0];
            if (total >= 3'd4) begin
              port_A_addr    <= wr_addr;
              port_A_data_in <= merged[31:0];
              port_A_we      <= 1'b1;
              acc            <= merged[63:32];
              acc_n          <= 2'(total - 3'd4);
              state          <= WR;
            end else begin
              acc   <= merged[31:0];
              acc_n <= total[1:0];
              state <= ret;
            end
          end
        end
        WR: begin
          wr_addr <= wr_addr + 16'd4;
          state   <= ret;
        end
        FLUSH: begin
          if (have_run) begin
            emit_sym <= run_sym;
            emit_cnt <= run_cnt;
            have_run <= 1'b0;
            ret      <= FLUSH;
            state    <= EMIT;
          end else if (acc_n != 2'd0) begin
            port_A_addr    <= wr_addr;
            port_A_data_in <= acc;
            port_A_we      <= 1'b1;
            wr_addr        <= wr_addr + 16'd4;
            acc            <= '0;
            acc_n          <= '0;
          end else begin
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
